// File: rtl/usb_rx_byte_assembler.sv
// usb_rx_byte_assembler: SYNC detection, bit unstuffing and LSB-first byte assembly for the USB FS receive path
module usb_rx_byte_assembler #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int STUFF_LEN = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_orig,
    input  logic       shift_enable,
    input  logic       eop,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       receiving,
    output logic       rx_error,
    output logic       packet_done
);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, ERROR, EOP_WAIT} state_t;
    state_t state;
    logic [7:0] sr, sr_next;
    logic [2:0] bit_cnt;
    logic [OW-1:0] ones, ones_next;
    logic stuff_hit;
    always_comb begin
        sr_next = {d_orig, sr[7:1]};
        stuff_hit = ones == STUFF_MAX;
        ones_next = !d_orig ? '0 : stuff_hit ? ones : ones + OW'(1);
    end
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            sr <= '0;
            bit_cnt <= '0;
            ones <= '0;
            rx_data <= '0;
            byte_valid <= 1'b0;
            receiving <= 1'b0;
            rx_error <= 1'b0;
            packet_done <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            packet_done <= 1'b0;
            if (shift_enable) begin
                case (state)
                    IDLE: if (!eop && !d_orig) begin
                        state <= SYNC;
                        sr <= sr_next;
                        bit_cnt <= 3'd1;
                        ones <= '0;
                        rx_error <= 1'b0;
                        receiving <= 1'b1;
                    end
                    SYNC: if (eop) begin
                        rx_error <= 1'b1;
                        state <= EOP_WAIT;
                    end else begin
                        sr <= sr_next;
                        ones <= ones_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= (sr_next == SYNC_BYTE) ? DATA : ERROR;
                            rx_error <= sr_next != SYNC_BYTE;
                        end
                    end
                    DATA: if (eop) begin
                        packet_done <= bit_cnt == 3'd0;
                        rx_error <= bit_cnt != 3'd0;
                        state <= EOP_WAIT;
                    end else if (stuff_hit && !d_orig) begin
                        ones <= '0;
                    end else if (stuff_hit) begin
                        rx_error <= 1'b1;
                        state <= ERROR;
                    end else begin
                        sr <= sr_next;
                        ones <= ones_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data <= sr_next;
                            byte_valid <= 1'b1;
                        end
                    end
                    ERROR: if (eop) state <= EOP_WAIT;
                    EOP_WAIT: if (!eop) begin
                        state <= IDLE;
                        receiving <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// tb_usb_rx_byte_assembler: table-driven strobe vectors with a byte scoreboard for usb_rx_byte_assembler
module tb_usb_rx_byte_assembler;
    logic clk = 1'b0, n_rst = 1'b0, d_orig = 1'b1, shift_enable = 1'b0, eop = 1'b0;
    logic [7:0] rx_data;
    logic byte_valid, receiving, rx_error, packet_done;

    usb_rx_byte_assembler dut (
        .clk(clk), .n_rst(n_rst), .d_orig(d_orig), .shift_enable(shift_enable), .eop(eop),
        .rx_data(rx_data), .byte_valid(byte_valid), .receiving(receiving),
        .rx_error(rx_error), .packet_done(packet_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic d; logic e; logic bv; logic pd; logic recv; logic err; logic [7:0] data; logic gap;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_hold = 8'h00;
    logic gap_mode = 1'b1;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic d, e, bv, pd, recv, err, input logic [7:0] data = 8'h00);
        vec_t x;
        x = '{d, e, bv, pd, recv, err, data, gap_mode};
        vecs.push_back(x);
    endtask

    task automatic sync8();
        for (int i = 0; i < 8; i++) v(i == 7, 0, 0, 0, 1, 0);
    endtask

    task automatic byte8(input logic [7:0] b);
        for (int i = 0; i < 8; i++) v(b[i], 0, i == 7, 0, 1, 0, b);
    endtask

    task automatic apply(input vec_t x, input int idx);
        d_orig = x.d;
        eop = x.e;
        shift_enable = 1'b1;
        if (x.bv) exp_q.push_back(x.data);
        @(negedge clk);
        if ((x.bv || byte_valid) && exp_q.size() > 0) exp_hold = exp_q.pop_front();
        chk($sformatf("v%0d byte_valid", idx), {7'd0, byte_valid}, {7'd0, x.bv});
        chk($sformatf("v%0d packet_done", idx), {7'd0, packet_done}, {7'd0, x.pd});
        chk($sformatf("v%0d receiving", idx), {7'd0, receiving}, {7'd0, x.recv});
        chk($sformatf("v%0d rx_error", idx), {7'd0, rx_error}, {7'd0, x.err});
        chk($sformatf("v%0d rx_data", idx), rx_data, exp_hold);
        if (x.gap) begin
            shift_enable = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d byte_valid width", idx), {7'd0, byte_valid}, 8'd0);
            chk($sformatf("v%0d packet_done width", idx), {7'd0, packet_done}, 8'd0);
        end
    endtask

    task automatic run_all(input string tag);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        shift_enable = 1'b0;
        vecs.delete();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: %0d bytes never seen, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rx_data"}, rx_data, 8'h00);
        chk({tag, " byte_valid"}, {7'd0, byte_valid}, 8'd0);
        chk({tag, " receiving"}, {7'd0, receiving}, 8'd0);
        chk({tag, " rx_error"}, {7'd0, rx_error}, 8'd0);
        chk({tag, " packet_done"}, {7'd0, packet_done}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        n_rst = 1'b1;
        @(negedge clk);
        // idle line: J bits and a stray eop are ignored
        v(1, 0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0);
        // clean packet 0xA5
        sync8();
        byte8(8'hA5);
        v(0, 1, 0, 1, 1, 0);
        v(0, 1, 0, 0, 1, 0);
        v(1, 0, 0, 0, 0, 0);
        // stuffing, strobes back to back
        gap_mode = 1'b0;
        sync8();
        for (int i = 0; i < 5; i++) v(1, 0, 0, 0, 1, 0);
        v(0, 0, 0, 0, 1, 0);
        v(1, 0, 0, 0, 1, 0);
        v(1, 0, 0, 0, 1, 0);
        v(1, 0, 1, 0, 1, 0, 8'hFF);
        gap_mode = 1'b1;
        v(0, 1, 0, 1, 1, 0);
        v(1, 0, 0, 0, 0, 0);
        // stuff violation: SYNC's trailing 1 plus five data 1s reach the limit
        sync8();
        for (int i = 0; i < 5; i++) v(1, 0, 0, 0, 1, 0);
        v(1, 0, 0, 0, 1, 1);
        v(1, 0, 0, 0, 1, 1);
        v(0, 1, 0, 0, 1, 1);
        v(1, 0, 0, 0, 0, 1);
        // bad SYNC, then a good SYNC clears the error; empty packet ends cleanly
        for (int i = 0; i < 8; i++) v(i >= 6, 0, 0, 0, 1, i == 7);
        v(0, 0, 0, 0, 1, 1);
        v(0, 1, 0, 0, 1, 1);
        v(1, 0, 0, 0, 0, 1);
        sync8();
        v(0, 1, 0, 1, 1, 0);
        v(1, 0, 0, 0, 0, 0);
        // EOP mid-byte
        sync8();
        v(1, 0, 0, 0, 1, 0);
        v(0, 0, 0, 0, 1, 0);
        v(1, 0, 0, 0, 1, 0);
        v(0, 1, 0, 0, 1, 1);
        v(1, 0, 0, 0, 0, 1);
        run_all("table");
        // reset mid-packet
        sync8();
        v(1, 0, 0, 0, 1, 0);
        v(0, 0, 0, 0, 1, 0);
        v(1, 0, 0, 0, 1, 0);
        v(1, 0, 0, 0, 1, 0);
        run_all("pre-reset");
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        chk_reset("mid reset");
        exp_hold = 8'h00;
        sync8();
        byte8(8'h3C);
        v(0, 1, 0, 1, 1, 0);
        v(1, 0, 0, 0, 0, 0);
        run_all("post-reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
